// File: rtl/multiplexor_4to1.sv
// Four-way word multiplexer with a registered output stage, valid flag and
// a pulse that marks a change of the accepted select code.
module multiplexor_4to1 #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [0:WIDTH-1] In1,
  input  logic [0:WIDTH-1] In2,
  input  logic [0:WIDTH-1] In3,
  input  logic [0:WIDTH-1] In4,
  input  logic [1:0]       Sel,
  input  logic             In_valid,
  input  logic             Hold,
  output logic [0:WIDTH-1] Out,
  output logic             Out_valid,
  output logic [1:0]       Sel_out,
  output logic             Sel_changed
);

  logic [0:WIDTH-1] selWord;
  logic [1:0]       lastSel;

  always_comb begin
    selWord = In1;
    unique case (Sel)
      2'd0: selWord = In1;
      2'd1: selWord = In2;
      2'd2: selWord = In3;
      2'd3: selWord = In4;
    endcase
  end

  // Rst beats Hold, Hold beats In_valid; lastSel only moves on an accept
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Out         <= '0;
      Out_valid   <= 1'b0;
      Sel_out     <= 2'd0;
      Sel_changed <= 1'b0;
      lastSel     <= 2'd0;
    end else if (Hold) begin
      Sel_changed <= 1'b0;
    end else if (In_valid) begin
      Out         <= selWord;
      Out_valid   <= 1'b1;
      Sel_out     <= Sel;
      Sel_changed <= (Sel != lastSel);
      lastSel     <= Sel;
    end else begin
      Out_valid   <= 1'b0;
      Sel_changed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multiplexor_4to1.sv
// Bench for multiplexor_4to1: directed scenarios followed by random traffic,
// all checked against a word-array reference model.
module tb_multiplexor_4to1;

  localparam int WIDTH = 32;

  logic             Clk = 1'b0;
  logic             Rst = 1'b0;
  logic [0:WIDTH-1] In1 = '0;
  logic [0:WIDTH-1] In2 = '0;
  logic [0:WIDTH-1] In3 = '0;
  logic [0:WIDTH-1] In4 = '0;
  logic [1:0]       Sel = 2'd0;
  logic             In_valid = 1'b0;
  logic             Hold = 1'b0;
  logic [0:WIDTH-1] Out;
  logic             Out_valid;
  logic [1:0]       Sel_out;
  logic             Sel_changed;

  int numChecks = 0;
  int numFails  = 0;

  // reference model state
  logic [31:0] expOut     = '0;
  logic        expValid   = 1'b0;
  int          expSel     = 0;
  logic        expChanged = 1'b0;
  int          expLast    = 0;

  multiplexor_4to1 #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Rst(Rst), .In1(In1), .In2(In2), .In3(In3), .In4(In4),
    .Sel(Sel), .In_valid(In_valid), .Hold(Hold), .Out(Out),
    .Out_valid(Out_valid), .Sel_out(Sel_out), .Sel_changed(Sel_changed)
  );

  always #10 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Model steps by the rules on the edge, then outputs are compared mid-cycle
  task automatic applyStimulus(input logic rst, input logic hold, input logic valid,
                               input int sel, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [31:0] d);
    logic [31:0] words [4];
    Rst = rst; Hold = hold; In_valid = valid; Sel = sel[1:0];
    In1 = a; In2 = b; In3 = c; In4 = d;
    words[0] = a; words[1] = b; words[2] = c; words[3] = d;
    @(posedge Clk);
    if (rst) begin
      expOut = '0; expValid = 1'b0; expSel = 0; expChanged = 1'b0; expLast = 0;
    end else if (hold) begin
      expChanged = 1'b0;
    end else if (valid) begin
      expOut = words[sel];
      expValid = 1'b1;
      expSel = sel;
      expChanged = (sel != expLast);
      expLast = sel;
    end else begin
      expValid = 1'b0;
      expChanged = 1'b0;
    end
    @(negedge Clk);
    checkOutput("out",         64'(Out),         64'(expOut));
    checkOutput("out_valid",   64'(Out_valid),   64'(expValid));
    checkOutput("sel_out",     64'(Sel_out),     64'(expSel));
    checkOutput("sel_changed", 64'(Sel_changed), 64'(expChanged));
  endtask

  initial begin
    @(negedge Clk);
    // reset with live-looking inputs
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 1, 2, 1, 2, 3, 4);
    checkOutput("reset_out", 64'(Out), 64'd0);

    // sweep all select codes
    for (int s = 0; s < 4; s++) applyStimulus(0, 0, 1, s, 1, 2, 3, 4);
    checkOutput("sweep_last", 64'(Out), 64'd4);

    // hold while select moves, then release
    applyStimulus(0, 0, 1, 2, 1, 2, 3, 4);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 3, 1, 2, 3, 4);
    checkOutput("hold_out", 64'(Out), 64'd3);
    applyStimulus(0, 0, 1, 3, 1, 2, 3, 4);
    checkOutput("release_chg", 64'(Sel_changed), 64'd1);

    // idle, then re-accept updated word
    applyStimulus(0, 0, 0, 3, 1, 2, 3, 32'hDEADBEEF);
    applyStimulus(0, 0, 1, 3, 1, 2, 3, 32'hDEADBEEF);
    checkOutput("idle_reaccept", 64'(Out), 64'hDEADBEEF);

    // numeric value preserved, index 0 is the MSB
    applyStimulus(0, 0, 1, 1, 32'hFFFFFFFF, 32'h80000000, 3, 4);
    checkOutput("msb_index0", 64'(Out[0]), 64'd1);
    checkOutput("lsb_index31", 64'(Out[WIDTH-1]), 64'd0);

    // reset collides with an accept, then first accept with Sel=0
    applyStimulus(1, 0, 1, 3, 1, 2, 3, 4);
    applyStimulus(0, 0, 1, 0, 5, 6, 7, 8);
    checkOutput("post_reset_chg", 64'(Sel_changed), 64'd0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                    $urandom, $urandom, $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/multiplexor_4to1.md
Name: multiplexor_4to1

Overview:
- Four-input, one-output word multiplexer with a registered output stage.
- Selects one of four equal-width data words (In1..In4) by a 2-bit select code.
- Presents the selected word one clock later, with a valid flag and a select-change indicator.
- Used as a datapath steering element in front of downstream registered logic.

Parameters:
- WIDTH, 32, data width of each input word and of Out (legal: 1..64).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Rst  input  1  synchronous, active-high reset.
- In1  input  WIDTH  data word selected when Sel=0.
- In2  input  WIDTH  data word selected when Sel=1.
- In3  input  WIDTH  data word selected when Sel=2.
- In4  input  WIDTH  data word selected when Sel=3.
- Sel  input  2  select code, unsigned.
- In_valid  input  1  qualifies In1..In4 and Sel for this cycle.
- Hold  input  1  freezes all registered outputs while high.
- Out  output  WIDTH  registered selected word.
- Out_valid  output  1  Out carries a word accepted on the previous edge.
- Sel_out  output  2  registered copy of the Sel code that produced Out.
- Sel_changed  output  1  one-cycle pulse: accepted Sel differs from the previously accepted Sel.

Behaviour:
- Interface: one clock (Clk); reset Rst is synchronous and active-high. No asynchronous reset paths.
- Data vectors: declared big-endian [0:WIDTH-1], index 0 = MSB. Numeric value is carried unchanged, e.g. In2 = 2 gives Out = 2.
- Reset: on any rising Clk with Rst=1, Out=0, Out_valid=0, Sel_out=0, Sel_changed=0, and the internal last-accepted-Sel register = 0.
  - Rst overrides Hold and In_valid.
  - Reset mid-stream discards the in-flight word.
- Priority per edge: Rst > Hold > In_valid.
- Hold=1 (Rst=0): Out, Out_valid, Sel_out and the last-Sel register retain their values. Sel_changed is forced to 0.
- Accept (Rst=0, Hold=0, In_valid=1):
  - Out <= In(Sel+1), i.e. Sel=0 gives In1, 1 gives In2, 2 gives In3, 3 gives In4.
  - Sel_out <= Sel.
  - Out_valid <= 1.
  - Sel_changed <= (Sel != last-accepted Sel).
  - last-accepted Sel <= Sel.
- Idle (Rst=0, Hold=0, In_valid=0): Out and Sel_out retain; Out_valid <= 0; Sel_changed <= 0.
- Latency: exactly one Clk from accept to Out. Back-to-back accepts every cycle are supported, giving full throughput.
- All four Sel codes are legal. Full case; no default-to-zero path other than reset.
- First accept after reset with Sel=0 gives Sel_changed=0, because reset value is 0.
- Inputs changing between edges have no effect on Out; only the values at the rising edge are used.
- No combinational path from any input to any output.

Test Plan:
- Reset: drive Rst=1 for 2 cycles with In1..In4 = 1,2,3,4 and Sel=2 -> Out=0, Out_valid=0, Sel_out=0, Sel_changed=0.
- Sweep: In1..In4 = 1,2,3,4, In_valid=1, Sel stepped 0,1,2,3, one value every 20 ns (Clk period 20 ns) -> Out = 1,2,3,4 one cycle after each step. Out_valid=1 throughout. Sel_changed pulses on the steps to 1, 2 and 3.
- Hold: after Out=3 (Sel=2), assert Hold with Sel=3 for 3 cycles -> Out stays 3, Sel_out stays 2, Sel_changed=0. Release Hold -> next edge gives Out=4, Sel_changed=1.
- Idle: deassert In_valid and change In4 to 0xDEADBEEF -> Out_valid=0, Out unchanged. Reassert In_valid with Sel=3 -> Out=0xDEADBEEF.
- Full-width/endianness: In1=0xFFFFFFFF, In2=0x80000000, Sel=1 -> Out=0x80000000, with index 0 of Out = 1.
- Reset mid-stream: Rst=1 on the same edge as an accept with Sel=3 -> Out=0 and Out_valid=0. The next accept with Sel=0 gives Sel_changed=0.
